// File: rtl/i2c_cfg_pkg.sv
// Shared types for the I2C configuration sequencer: LUT opcodes, FSM states, entry payload.
package i2c_cfg_pkg;

    localparam int unsigned DEV_W  = 8;
    localparam int unsigned REG_W  = 16;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        OP_WRITE        = 2'd0,
        OP_WRITE_VERIFY = 2'd1,
        OP_DELAY        = 2'd2,
        OP_END          = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DISPATCH,
        ST_WR,
        ST_RD,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } state_e;

    typedef struct packed {
        op_e               op;
        logic [DEV_W-1:0]  dev_addr;
        logic [REG_W-1:0]  reg_addr;
        logic [DATA_W-1:0] reg_data;
    } entry_t;

endpackage

// File: rtl/i2c_cfg_delay.sv
// Delay timer: TICK_DIV-cycle prescaler feeding a tick down-counter.
// expired_c is high during the final cycle of the delay (or at once for a zero count).
module i2c_cfg_delay #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned DELAY_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DELAY_W-1:0] count,
    output logic               expired_c
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0]   pre_q;
    logic [DELAY_W-1:0] cnt_q;
    logic               last_pre_c;

    assign last_pre_c = (pre_q == PRE_W'(TICK_DIV - 1));
    assign expired_c  = (cnt_q == '0) || ((cnt_q == DELAY_W'(1)) && last_pre_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            pre_q <= '0;
            cnt_q <= count;
        end else if (cnt_q != '0) begin
            if (last_pre_c) begin
                pre_q <= '0;
                cnt_q <= cnt_q - DELAY_W'(1);
            end else begin
                pre_q <= pre_q + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Table-driven I2C register programming sequencer with NACK retry, readback verify,
// timed delays and first-failure index reporting.
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int unsigned LUT_AW     = 10,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned DELAY_W    = 16,
    parameter int unsigned AUTO_START = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [LUT_AW-1:0] lut_index,
    input  logic [1:0]        lut_op,
    input  logic [7:0]        lut_dev_addr,
    input  logic [15:0]       lut_reg_addr,
    input  logic [7:0]        lut_reg_data,
    output logic              i2c_write_req,
    input  logic              i2c_write_ack,
    output logic              i2c_read_req,
    input  logic              i2c_read_ack,
    input  logic [7:0]        i2c_read_data,
    input  logic              i2c_err,
    output logic [7:0]        i2c_dev_addr,
    output logic [15:0]       i2c_reg_addr,
    output logic [7:0]        i2c_wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LUT_AW-1:0] err_index
);

    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e              state_q, state_d;
    entry_t              entry_q, entry_d, lut_entry_c;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [LUT_AW-1:0]   idx_d, err_idx_d;
    logic                wreq_d, rreq_d, busy_d, done_d, error_d;
    logic                delay_load, delay_expired_c, fail, start_pass, can_retry;

    assign lut_entry_c = '{op: op_e'(lut_op), dev_addr: lut_dev_addr,
                           reg_addr: lut_reg_addr, reg_data: lut_reg_data};
    assign can_retry   = (retry_q < RETRY_W'(MAX_RETRY));

    assign i2c_dev_addr = entry_q.dev_addr;
    assign i2c_reg_addr = entry_q.reg_addr;
    assign i2c_wr_data  = entry_q.reg_data;

    i2c_cfg_delay #(
        .TICK_DIV (TICK_DIV),
        .DELAY_W  (DELAY_W)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .load      (delay_load),
        .count     (entry_q.reg_addr[DELAY_W-1:0]),
        .expired_c (delay_expired_c)
    );

    // Next-state and next-output logic; a dropped req for one cycle marks a retry gap.
    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        retry_d    = retry_q;
        idx_d      = lut_index;
        err_idx_d  = err_index;
        wreq_d     = i2c_write_req;
        rreq_d     = i2c_read_req;
        busy_d     = busy;
        done_d     = done;
        error_d    = error;
        delay_load = 1'b0;
        fail       = 1'b0;
        start_pass = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start || (AUTO_START != 0)) start_pass = 1'b1;
            end
            ST_FETCH: begin
                entry_d = lut_entry_c;
                state_d = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                case (entry_q.op)
                    OP_END: begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    OP_DELAY: begin
                        delay_load = 1'b1;
                        state_d    = ST_WAIT;
                    end
                    default: begin
                        wreq_d  = 1'b1;
                        state_d = ST_WR;
                    end
                endcase
            end
            ST_WR: begin
                if (!i2c_write_req) begin
                    wreq_d = 1'b1;
                end else if (i2c_write_ack) begin
                    wreq_d = 1'b0;
                    if (i2c_err && can_retry) begin
                        retry_d = retry_q + RETRY_W'(1);
                    end else if (i2c_err) begin
                        fail = 1'b1;
                    end else if (entry_q.op == OP_WRITE_VERIFY) begin
                        rreq_d  = 1'b1;
                        retry_d = '0;
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_RD: begin
                if (!i2c_read_req) begin
                    rreq_d = 1'b1;
                end else if (i2c_read_ack) begin
                    rreq_d = 1'b0;
                    if (i2c_err && can_retry) begin
                        retry_d = retry_q + RETRY_W'(1);
                    end else if (i2c_err || (i2c_read_data != entry_q.reg_data)) begin
                        fail = 1'b1;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_WAIT: begin
                if (delay_expired_c) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                retry_d = '0;
                if (lut_index == '1) begin
                    error_d = 1'b1;
                    if (!error) err_idx_d = lut_index;
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = lut_index + LUT_AW'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                if (start) start_pass = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Failures are recorded and the pass carries on with the next entry.
        if (fail) begin
            error_d = 1'b1;
            if (!error) err_idx_d = lut_index;
            state_d = ST_NEXT;
        end

        if (start_pass) begin
            state_d   = ST_FETCH;
            idx_d     = '0;
            retry_d   = '0;
            error_d   = 1'b0;
            err_idx_d = '0;
            done_d    = 1'b0;
            busy_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            entry_q       <= '0;
            retry_q       <= '0;
            lut_index     <= '0;
            err_index     <= '0;
            i2c_write_req <= 1'b0;
            i2c_read_req  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state_q       <= state_d;
            entry_q       <= entry_d;
            retry_q       <= retry_d;
            lut_index     <= idx_d;
            err_index     <= err_idx_d;
            i2c_write_req <= wreq_d;
            i2c_read_req  <= rreq_d;
            busy          <= busy_d;
            done          <= done_d;
            error         <= error_d;
        end
    end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Self-checking bench: behavioural I2C master answering a bench-built LUT, with a
// scoreboard of expected master transactions and end-of-pass status checks.
module tb_i2c_cfg_sequencer;

    localparam int unsigned AW   = 3;
    localparam int unsigned MAXR = 3;
    localparam int unsigned TDIV = 10;
    localparam int unsigned DW   = 16;
    localparam int unsigned N    = 1 << AW;

    localparam logic [1:0] T_WR  = 2'd0;
    localparam logic [1:0] T_WV  = 2'd1;
    localparam logic [1:0] T_DLY = 2'd2;
    localparam logic [1:0] T_END = 2'd3;

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] idx;
        logic [7:0]    dev;
        logic [15:0]   regad;
        logic [7:0]    data;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [AW-1:0] lut_index, err_index;
    logic [1:0]  lut_op;
    logic [7:0]  lut_dev_addr, lut_reg_data, i2c_read_data, i2c_dev_addr, i2c_wr_data;
    logic [15:0] lut_reg_addr, i2c_reg_addr;
    logic i2c_write_req, i2c_write_ack, i2c_read_req, i2c_read_ack, i2c_err;
    logic busy, done, error;

    always #5 clk = ~clk;

    i2c_cfg_sequencer #(
        .LUT_AW(AW), .MAX_RETRY(MAXR), .TICK_DIV(TDIV), .DELAY_W(DW), .AUTO_START(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .lut_index(lut_index),
        .lut_op(lut_op), .lut_dev_addr(lut_dev_addr), .lut_reg_addr(lut_reg_addr),
        .lut_reg_data(lut_reg_data), .i2c_write_req(i2c_write_req),
        .i2c_write_ack(i2c_write_ack), .i2c_read_req(i2c_read_req),
        .i2c_read_ack(i2c_read_ack), .i2c_read_data(i2c_read_data), .i2c_err(i2c_err),
        .i2c_dev_addr(i2c_dev_addr), .i2c_reg_addr(i2c_reg_addr), .i2c_wr_data(i2c_wr_data),
        .busy(busy), .done(done), .error(error), .err_index(err_index)
    );

    logic [1:0]  tb_op  [N];
    logic [7:0]  tb_dev [N];
    logic [15:0] tb_reg [N];
    logic [7:0]  tb_dat [N];
    logic [7:0]  tb_rdv [N];
    int          tb_nack[N];

    assign lut_op       = tb_op[lut_index];
    assign lut_dev_addr = tb_dev[lut_index];
    assign lut_reg_addr = tb_reg[lut_index];
    assign lut_reg_data = tb_dat[lut_index];

    txn_t exp_q[$];
    int   wr_seen[N];
    int   rd_seen;
    int   nack_left[N];
    int   stamp[N];
    bit   hold_ack = 1'b0;
    bit   exp_err;
    int   exp_eidx, exp_last;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural master: random latency, NACKs from a per-entry budget, readback table.
    initial begin : master
        int   lat;
        bit   in_txn, is_rd;
        txn_t got, want;
        i2c_write_ack = 1'b0;
        i2c_read_ack  = 1'b0;
        i2c_err       = 1'b0;
        i2c_read_data = 8'h00;
        in_txn = 1'b0;
        is_rd  = 1'b0;
        lat    = 0;
        forever begin
            @(negedge clk);
            i2c_write_ack = 1'b0;
            i2c_read_ack  = 1'b0;
            i2c_err       = 1'b0;
            if (rst) begin
                in_txn = 1'b0;
            end else if (!in_txn) begin
                if (i2c_write_req || i2c_read_req) begin
                    in_txn = 1'b1;
                    is_rd  = i2c_read_req;
                    lat    = int'($urandom_range(0, 3));
                    check_eq("one_req", 64'(i2c_write_req & i2c_read_req), 64'(0));
                    got = '{rd: i2c_read_req, idx: lut_index, dev: i2c_dev_addr,
                            regad: i2c_reg_addr, data: i2c_wr_data};
                    if (exp_q.size() > 0) want = exp_q.pop_front();
                    else want = '0;
                    check_eq("txn", 64'(got), 64'(want));
                    if (is_rd) rd_seen++;
                    else wr_seen[lut_index]++;
                end
            end else if (!hold_ack) begin
                if (lat > 0) begin
                    lat--;
                end else begin
                    in_txn = 1'b0;
                    if (is_rd) begin
                        i2c_read_ack  = 1'b1;
                        i2c_read_data = tb_rdv[lut_index];
                    end else begin
                        i2c_write_ack = 1'b1;
                        if (nack_left[lut_index] > 0) begin
                            i2c_err = 1'b1;
                            nack_left[lut_index]--;
                        end
                    end
                end
            end
        end
    end

    task automatic clear_lut();
        for (int i = 0; i < N; i++) begin
            tb_op[i]   = T_END;
            tb_dev[i]  = 8'h40 + 8'(2 * i);
            tb_reg[i]  = 16'h3000 + 16'(i * 17);
            tb_dat[i]  = 8'hA0 + 8'(i);
            tb_rdv[i]  = 8'hA0 + 8'(i);
            tb_nack[i] = 0;
        end
    endtask

    // Reference model of one pass: expected transactions and final status.
    task automatic build_expect();
        bit ended, fail;
        int att;
        exp_q.delete();
        exp_err  = 1'b0;
        exp_eidx = 0;
        exp_last = 0;
        ended    = 1'b0;
        rd_seen  = 0;
        for (int i = 0; i < N; i++) begin
            wr_seen[i]   = 0;
            nack_left[i] = tb_nack[i];
        end
        for (int i = 0; i < N && !ended; i++) begin
            exp_last = i;
            fail = 1'b0;
            if (tb_op[i] == T_END) begin
                ended = 1'b1;
            end else if (tb_op[i] != T_DLY) begin
                att = (tb_nack[i] > int'(MAXR)) ? int'(MAXR) + 1 : tb_nack[i] + 1;
                for (int a = 0; a < att; a++)
                    exp_q.push_back('{rd: 1'b0, idx: AW'(i), dev: tb_dev[i],
                                      regad: tb_reg[i], data: tb_dat[i]});
                if (tb_nack[i] > int'(MAXR)) begin
                    fail = 1'b1;
                end else if (tb_op[i] == T_WV) begin
                    exp_q.push_back('{rd: 1'b1, idx: AW'(i), dev: tb_dev[i],
                                      regad: tb_reg[i], data: tb_dat[i]});
                    if (tb_rdv[i] != tb_dat[i]) fail = 1'b1;
                end
            end
            if (fail && !exp_err) begin
                exp_err  = 1'b1;
                exp_eidx = i;
            end
        end
        if (!ended && !exp_err) begin
            exp_err  = 1'b1;
            exp_eidx = N - 1;
        end
    endtask

    task automatic start_pass(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_start_busy"}, 64'(busy), 64'(1));
        check_eq({tag, "_start_idx"}, 64'(lut_index), 64'(0));
        check_eq({tag, "_start_done"}, 64'(done), 64'(0));
        check_eq({tag, "_start_error"}, 64'(error), 64'(0));
    endtask

    // Runs until done (bounded); optionally pokes start mid-pass; stamps index changes.
    task automatic wait_pass(input int poke);
        int cyc;
        logic [AW-1:0] prev;
        cyc  = 0;
        prev = lut_index;
        for (int i = 0; i < N; i++) stamp[i] = -1;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == poke);
            if (lut_index != prev) begin
                stamp[lut_index] = cyc;
                prev = lut_index;
            end
        end
        start = 1'b0;
    endtask

    task automatic end_checks(input string tag);
        check_eq({tag, "_done"}, 64'(done), 64'(1));
        check_eq({tag, "_busy"}, 64'(busy), 64'(0));
        check_eq({tag, "_error"}, 64'(error), 64'(exp_err));
        check_eq({tag, "_err_index"}, 64'(err_index), 64'(exp_eidx));
        check_eq({tag, "_last_idx"}, 64'(lut_index), 64'(exp_last));
        check_eq({tag, "_sb_left"}, 64'(exp_q.size()), 64'(0));
        check_eq({tag, "_reqs_low"}, 64'({i2c_write_req, i2c_read_req}), 64'(0));
    endtask

    initial begin
        // T1: auto-start after reset, three plain writes.
        clear_lut();
        for (int i = 0; i < 3; i++) tb_op[i] = T_WR;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_reqs", 64'({i2c_write_req, i2c_read_req}), 64'(0));
        check_eq("rst_status", 64'({busy, done, error}), 64'(0));
        check_eq("rst_idx", 64'(lut_index), 64'(0));
        check_eq("rst_err_index", 64'(err_index), 64'(0));
        build_expect();
        rst = 1'b0;
        wait_pass(0);
        end_checks("t1");
        check_eq("t1_writes", 64'(wr_seen[0] + wr_seen[1] + wr_seen[2]), 64'(3));
        check_eq("t1_end_idx", 64'(lut_index), 64'(3));

        // T2: readback mismatch is flagged, no retry, pass continues.
        clear_lut();
        tb_op[0]  = T_WV;
        tb_dat[0] = 8'h5A;
        tb_rdv[0] = 8'h5B;
        tb_op[1]  = T_WR;
        build_expect();
        start_pass("t2");
        wait_pass(0);
        end_checks("t2");
        check_eq("t2_reads", 64'(rd_seen), 64'(1));
        check_eq("t2_idx1_written", 64'(wr_seen[1]), 64'(1));

        // T3: retries exhausted on entry 2, entry 3 still written.
        clear_lut();
        for (int i = 0; i < 4; i++) tb_op[i] = T_WR;
        tb_nack[2] = 4;
        build_expect();
        start_pass("t3");
        wait_pass(0);
        end_checks("t3");
        check_eq("t3_idx2_writes", 64'(wr_seen[2]), 64'(4));
        check_eq("t3_idx3_writes", 64'(wr_seen[3]), 64'(1));
        check_eq("t3_err_index", 64'(err_index), 64'(2));

        // T4: two NACKs then success; a start pulse mid-pass must be ignored.
        clear_lut();
        for (int i = 0; i < 3; i++) tb_op[i] = T_WR;
        tb_op[1]   = T_WV;
        tb_nack[1] = 2;
        build_expect();
        start_pass("t4");
        wait_pass(6);
        end_checks("t4");
        check_eq("t4_idx1_writes", 64'(wr_seen[1]), 64'(3));
        check_eq("t4_idx0_writes", 64'(wr_seen[0]), 64'(1));

        // T5: delay timing, 2 ticks then 0 ticks.
        clear_lut();
        tb_op[0]  = T_DLY;
        tb_reg[0] = 16'd2;
        tb_op[1]  = T_DLY;
        tb_reg[1] = 16'd0;
        tb_op[2]  = T_WR;
        build_expect();
        start_pass("t5");
        wait_pass(0);
        end_checks("t5");
        check_eq("t5_delay2_cycles", 64'(stamp[1]), 64'(23));
        check_eq("t5_delay0_cycles", 64'(stamp[2] - stamp[1]), 64'(4));

        // T6: table without END overruns at the last index.
        clear_lut();
        for (int i = 0; i < N; i++) tb_op[i] = T_WR;
        build_expect();
        start_pass("t6");
        wait_pass(0);
        end_checks("t6");
        check_eq("t6_err_index", 64'(err_index), 64'(N - 1));
        check_eq("t6_last_written", 64'(wr_seen[N-1]), 64'(1));

        // T7: reset while a write request is outstanding, then auto-start again.
        clear_lut();
        tb_op[0] = T_WR;
        build_expect();
        hold_ack = 1'b1;
        start_pass("t7");
        for (int i = 0; i < 20 && !i2c_write_req; i++) @(negedge clk);
        check_eq("t7_req_up", 64'(i2c_write_req), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check_eq("t7_req_dropped", 64'(i2c_write_req), 64'(0));
        check_eq("t7_busy_dropped", 64'(busy), 64'(0));
        hold_ack = 1'b0;
        clear_lut();
        tb_op[0] = T_WR;
        tb_op[1] = T_WR;
        build_expect();
        @(negedge clk);
        rst = 1'b0;
        wait_pass(0);
        end_checks("t7");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
